// File: rtl/pulse_pkg.sv
// pulse_pkg: shared types, decoder function codes and window comparators for the pulse sequencer
package pulse_pkg;

   localparam int PULSE_W = 32;

   localparam logic [7:0] FC_SINGLE = 8'h11;
   localparam logic [7:0] FC_DOUBLE = 8'h12;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
   typedef enum logic {SINGLE = 1'b0, DOUBLE = 1'b1} mode_e;

   typedef struct packed {
      mode_e              mode;
      logic [PULSE_W-1:0] s1;
      logic [PULSE_W-1:0] e1;
      logic [PULSE_W-1:0] s2;
      logic [PULSE_W-1:0] e2;
   } pulse_cfg_t;

   // Half-open window test shared by the run-time comparator and set validation
   function automatic logic in_range(input logic [PULSE_W-1:0] v, input logic [PULSE_W-1:0] lo,
                                     input logic [PULSE_W-1:0] hi);
      return v >= lo && v < hi;
   endfunction

   // s1 < e1, plus e1 <= s2 < e2 for double mode
   function automatic logic cfg_ok(input pulse_cfg_t c);
      return in_range(c.s1, c.s1, c.e1) && (c.mode == SINGLE || in_range(c.s2, c.e1, c.e2));
   endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// pulse_sequencer_if: decoder-side timing words, trigger and status outputs; PULSE_REPEAT_EN adds repeat_req
interface pulse_sequencer_if #(parameter int W = pulse_pkg::PULSE_W);

   logic         cfg_valid;
   logic         cfg_mode;
   logic [W-1:0] cfg_s1;
   logic [W-1:0] cfg_e1;
   logic [W-1:0] cfg_s2;
   logic [W-1:0] cfg_e2;
   logic         trigger;
`ifdef PULSE_REPEAT_EN
   logic         repeat_req;
`endif
   logic         pulse_out;
   logic         busy;
   logic         done;
   logic         cfg_err;
   logic         cfg_loaded;

   modport master (
      output cfg_valid, cfg_mode, cfg_s1, cfg_e1, cfg_s2, cfg_e2, trigger,
`ifdef PULSE_REPEAT_EN
      output repeat_req,
`endif
      input  pulse_out, busy, done, cfg_err, cfg_loaded
   );

   modport slave (
      input  cfg_valid, cfg_mode, cfg_s1, cfg_e1, cfg_s2, cfg_e2, trigger,
`ifdef PULSE_REPEAT_EN
      input  repeat_req,
`endif
      output pulse_out, busy, done, cfg_err, cfg_loaded
   );

endinterface

// File: rtl/pulse_window_cmp.sv
// pulse_window_cmp: combinational in-window and final-cycle flags for counter value k
module pulse_window_cmp
   import pulse_pkg::*;
(
   input  logic [PULSE_W-1:0] k,
   input  pulse_cfg_t         cfg,
   output logic               in_win,
   output logic               last
);

   assign in_win = in_range(k, cfg.s1, cfg.e1) || (cfg.mode == DOUBLE && in_range(k, cfg.s2, cfg.e2));
   assign last   = k == (cfg.mode == DOUBLE ? cfg.e2 : cfg.e1);

endmodule

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: active/pending timing sets and single/double pulse runs; PULSE_REPEAT_EN enables back-to-back runs
module pulse_sequencer
   import pulse_pkg::*;
#(
   parameter int W = PULSE_W
) (
   input logic              clock,
   input logic              rst_n,
   pulse_sequencer_if.slave bus
);

   state_e     state;
   pulse_cfg_t act, pend, cand, cmp_cfg;
   logic       pend_v, rep, rep_q, last_q, in_win, last, cand_ok;
   logic [W-1:0] k, k_nxt;

   assign cand    = '{mode: mode_e'(bus.cfg_mode), s1: bus.cfg_s1, e1: bus.cfg_e1, s2: bus.cfg_s2, e2: bus.cfg_e2};
   assign cand_ok = cfg_ok(cand);
   assign k_nxt   = state == RUN ? k + W'(1) : '0;
   assign cmp_cfg = state == DONE && pend_v ? pend : act;

`ifdef PULSE_REPEAT_EN
   assign rep = bus.repeat_req;
`else
   assign rep = 1'b0;
`endif

   // The comparator looks at the next counter value so pulse_out lines up with k
   pulse_window_cmp u_cmp (
      .k      (k_nxt),
      .cfg    (cmp_cfg),
      .in_win (in_win),
      .last   (last)
   );

   // Run FSM, set loading/promotion and registered status outputs
   always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
         state          <= IDLE;
         k              <= '0;
         act            <= '0;
         pend           <= '0;
         pend_v         <= 1'b0;
         rep_q          <= 1'b0;
         last_q         <= 1'b0;
         bus.pulse_out  <= 1'b0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.cfg_err    <= 1'b0;
         bus.cfg_loaded <= 1'b0;
      end else begin
         bus.cfg_err <= bus.cfg_valid && !cand_ok;
         bus.done    <= 1'b0;
         case (state)
            IDLE: if (bus.trigger && bus.cfg_loaded) begin
               state         <= RUN;
               k             <= k_nxt;
               last_q        <= last;
               bus.pulse_out <= in_win;
               bus.busy      <= 1'b1;
            end
            RUN: if (last_q) begin
               state         <= DONE;
               rep_q         <= rep;
               bus.pulse_out <= 1'b0;
               bus.done      <= 1'b1;
            end else begin
               k             <= k_nxt;
               last_q        <= last;
               bus.pulse_out <= in_win;
            end
            default: begin
               if (pend_v) begin
                  act    <= pend;
                  pend_v <= 1'b0;
               end
               if (rep_q) begin
                  state         <= RUN;
                  k             <= k_nxt;
                  last_q        <= last;
                  bus.pulse_out <= in_win;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
         endcase
         if (bus.cfg_valid && cand_ok) begin
            if (state == IDLE && !bus.trigger) begin
               act            <= cand;
               bus.cfg_loaded <= 1'b1;
            end else begin
               pend   <= cand;
               pend_v <= 1'b1;
            end
         end
      end

endmodule
